// File: rtl/ro_puf_evaluator.sv
// Ring-oscillator PUF evaluator: races or windows two selected ROs and reports which one is faster.
// Latency: 5+N cycles from accepted start to done (1 when rejected); start is dropped while busy.
module ro_puf_evaluator #(
   parameter int N_RO         = 16,
   parameter int SEL_W        = 4,
   parameter int COUNTER_BITS = 8,
   parameter int WINDOW_BITS  = 12
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic [WINDOW_BITS-1:0]  window_len,
   input  logic [SEL_W-1:0]        sel0,
   input  logic [SEL_W-1:0]        sel1,
   input  logic [N_RO-1:0]         ro_out,
   output logic                    busy,
   output logic                    done,
   output logic                    response,
   output logic                    tie,
   output logic                    invalid,
   output logic [COUNTER_BITS-1:0] count0,
   output logic [COUNTER_BITS-1:0] count1
);

   typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

   localparam logic [COUNTER_BITS-1:0] MAX_VALUE = '1;
   localparam logic [SEL_W:0]          N_RO_LIM  = (SEL_W+1)'(N_RO);

   state_t                  state;
   state_t                  state_nxt;
   logic [SEL_W-1:0]        sel0_q;
   logic [SEL_W-1:0]        sel1_q;
   logic                    mode_q;
   logic [WINDOW_BITS-1:0]  window_q;
   logic [WINDOW_BITS-1:0]  window_cnt;
   logic [1:0]              settle_cnt;
   logic [2:0]              sync0;
   logic [2:0]              sync1;
   logic [COUNTER_BITS-1:0] cnt0;
   logic [COUNTER_BITS-1:0] cnt1;
   logic [COUNTER_BITS-1:0] cnt0_inc;
   logic [COUNTER_BITS-1:0] cnt1_inc;
   logic                    edge0;
   logic                    edge1;
   logic                    bad_req;
   logic                    counting;
   logic                    hit0;
   logic                    hit1;

   always_comb begin
      edge0     = sync0[1] & ~sync0[2];
      edge1     = sync1[1] & ~sync1[2];
      cnt0_inc  = (edge0 && cnt0 != MAX_VALUE) ? cnt0 + COUNTER_BITS'(1) : cnt0;
      cnt1_inc  = (edge1 && cnt1 != MAX_VALUE) ? cnt1 + COUNTER_BITS'(1) : cnt1;
      // The cycle the window counter equals the length is the closing cycle; no edges are taken in it.
      counting  = (state == COUNT) && (window_cnt != window_q);
      hit0      = mode_q && (cnt0_inc == MAX_VALUE);
      hit1      = mode_q && (cnt1_inc == MAX_VALUE);
      bad_req   = (sel0 == sel1) || ({1'b0, sel0} >= N_RO_LIM) ||
                  ({1'b0, sel1} >= N_RO_LIM) || (window_len == '0);
      busy      = (state != IDLE);
      done      = (state == DONE);
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = bad_req ? DONE : SETTLE;
         SETTLE:  if (settle_cnt == 2'd2) state_nxt = COUNT;
         COUNT:   if (!counting || hit0 || hit1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         sel0_q     <= '0;
         sel1_q     <= '0;
         mode_q     <= 1'b0;
         window_q   <= '0;
         window_cnt <= '0;
         settle_cnt <= '0;
         sync0      <= '0;
         sync1      <= '0;
         cnt0       <= '0;
         cnt1       <= '0;
         response   <= 1'b0;
         tie        <= 1'b0;
         invalid    <= 1'b0;
         count0     <= '0;
         count1     <= '0;
      end else begin
         state <= state_nxt;
         sync0 <= {sync0[1:0], ro_out[sel0_q]};
         sync1 <= {sync1[1:0], ro_out[sel1_q]};
         case (state)
            IDLE: begin
               if (start) begin
                  sel0_q     <= sel0;
                  sel1_q     <= sel1;
                  mode_q     <= mode;
                  window_q   <= window_len;
                  window_cnt <= '0;
                  settle_cnt <= '0;
                  cnt0       <= '0;
                  cnt1       <= '0;
                  response   <= 1'b0;
                  tie        <= 1'b0;
                  count0     <= '0;
                  count1     <= '0;
                  invalid    <= bad_req;
               end
            end
            SETTLE: settle_cnt <= settle_cnt + 2'd1;
            COUNT: begin
               if (!counting) begin
                  count0   <= cnt0;
                  count1   <= cnt1;
                  tie      <= (cnt0 == cnt1);
                  response <= (cnt1 > cnt0);
               end else begin
                  cnt0       <= cnt0_inc;
                  cnt1       <= cnt1_inc;
                  window_cnt <= window_cnt + WINDOW_BITS'(1);
                  if (hit0 || hit1) begin
                     count0   <= cnt0_inc;
                     count1   <= cnt1_inc;
                     tie      <= hit0 && hit1;
                     response <= hit1 && !hit0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
